cordic_sincos_pipe: RTL and testbench
=====================================

// Module: cordic_sincos_pipe
// PURPOSE
//  Parametrised pipelined CORDIC rotator: IEEE-754 single angle (radians) in, sin and cos out (float32).
//  Successor to the fixed 3-stage cosine core, adding:
//    - configurable iteration/stage split
//    - valid/ready handshake with backpressure and a tag
//    - quadrant folding to the full [-pi, pi] range
//    - out-of-range flag
//  Sits between the custom-instruction wrapper and the float unpack/pack helpers.
// PARAMETERS
//  WIDTH       22  fractional bits of internal fixed point; datapath is WIDTH+2 bits signed
//  ITERATIONS  16  CORDIC micro-rotations, 1..WIDTH+2
//  STAGES      4   pipeline register stages, 1..ITERATIONS
//  TAG_W       4   width of the user tag carried alongside each sample
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      synchronous, active-high
//  clk_en     in   1      global enable; low = whole pipeline frozen
//  in_valid   in   1      angle/tag valid
//  in_ready   out  1      block accepts a sample this cycle
//  angle      in   32     float32 radians
//  in_tag     in   TAG_W  user tag
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sin_out    out  32     float32 sin(angle)
//  cos_out    out  32     float32 cos(angle)
//  out_err    out  1      |angle| > pi; sin_out = cos_out = 0
//  out_tag    out  TAG_W  tag of this result
// BEHAVIOUR
//  - advance = clk_en & (~out_valid | out_ready); in_ready = advance. Transfer on in_valid & in_ready.
//  - Pipeline is rigid (no bubble collapse):
//    - every stage register loads from its predecessor when advance = 1, else holds;
//    - stage 0 valid loads in_valid & in_ready.
//  - Latency: exactly STAGES advancing cycles from accept to out_valid. Throughput 1/cycle when never stalled.
//  - Front end, combinational before stage 0:
//    - unpack angle to signed fixed a (WIDTH frac bits);
//    - if |a| > pi/2: a' = a - sgn(a)*pi, set neg flag;
//    - |a| > pi: err = 1.
//  - Iterations: x0 = K = round(0.6072529350 * 2^WIDTH), y0 = 0, z0 = a'.
//    - Stage s holds iterations ceil/floor split of ITERATIONS; the earlier stages take the extra ones.
//  - Back end, after last stage, combinational into output regs:
//    - negate x, y if neg;
//    - pack to float;
//    - zero both if err.
//  - Arithmetic: two's complement WIDTH+2 bits, arithmetic shift right by iteration index, wrap-free within range.
//    - Result accuracy: |error| <= 2^-(ITERATIONS-2) absolute.
//  - Reset: all stage valids, out_valid, out_err = 0; sin_out, cos_out, out_tag = 0. Data regs also cleared.
//    - Reset mid-flight discards all in-flight samples; in_ready = 0 during reset cycle.
//  - clk_en = 0: no state change (valid and data hold); in_ready = 0. Differs from old core, which zeroed.
//  - out_valid & ~out_ready: outputs stable until taken. Simultaneous take + accept in same cycle is legal.
//  - Samples emerge in acceptance order; no reordering, no drop.
// STRUCTURE
//  - cordic_pkg:
//    - atan table function atan_q(i, WIDTH);
//    - gain constant function k_q(WIDTH);
//    - PI_Q / HALF_PI_Q functions;
//    - stage boundary function first_iter(s, ITERATIONS, STAGES);
//    - typedef of the stage payload struct (x, y, z, neg, err, tag, valid).
//  - Sub-module cordic_stage: combinational chain of existing engine instances for iterations [lo, hi), plus its output register with advance enable.
//  - Top instantiates STAGES cordic_stage via generate, together with the existing unpacker/packer helpers.
// TESTING
//  1. angle 0x00000000, out_ready=1 -> after STAGES cycles cos_out ~= 0x3F800000, sin_out ~= 0.0 (abs err <= 2^-14), out_err=0.
//  2. angle pi/6 0x3F060A92 -> sin ~= 0.5, cos ~= 0.8660254 (abs err <= 2^-14).
//  3. angle 3.0 0x40400000 (fold) -> cos ~= -0.9899925, sin ~= 0.1411200; angle -3.0 -> sin ~= -0.1411200.
//  4. angle 4.0 0x40800000, tag 5 -> out_err=1, sin_out=cos_out=0, out_tag=5.
//  5. Backpressure:
//     - stream 8 samples, tags 0..7, with out_ready low for 5 cycles mid-stream;
//     - expect all 8 out in order and outputs stable while stalled.
//  6. Freeze, then reset:
//     - clk_en low 3 cycles mid-stream -> valid/data unchanged;
//     - then reset pulse -> out_valid=0 next cycle;
//     - no stale result after release.

Source files
------------

// File: rtl/cordic_pkg.sv
// Shared constants, table builders, float helpers and the stage control payload
// for the pipelined CORDIC sin/cos rotator.
package cordic_pkg;

    typedef struct packed {
        logic valid;
        logic neg;
        logic err;
    } stage_ctrl_t;

    function automatic real pow2(input int unsigned n);
        real r;
        r = 1.0;
        for (int i = 0; i < int'(n); i++) r = r * 2.0;
        return r;
    endfunction

    // Real-to-longint cast rounds to nearest.
    function automatic longint round_q(input real v, input int unsigned width);
        return longint'(v * pow2(width));
    endfunction

    function automatic longint pi_q(input int unsigned width);
        return round_q(3.14159265358979323846, width);
    endfunction

    function automatic longint half_pi_q(input int unsigned width);
        return round_q(1.57079632679489661923, width);
    endfunction

    function automatic longint k_q(input int unsigned width);
        return round_q(0.6072529350, width);
    endfunction

    function automatic longint atan_q(input int unsigned i, input int unsigned width);
        real x;
        real r;
        case (i)
            0:       r = 0.78539816339744831;
            1:       r = 0.46364760900080612;
            2:       r = 0.24497866312686414;
            3:       r = 0.12435499454676144;
            default: begin
                // Series tail below 2^-28 for i >= 4.
                x = 1.0 / pow2(i);
                r = x - x * x * x / 3.0 + x * x * x * x * x / 5.0;
            end
        endcase
        return round_q(r, width);
    endfunction

    // Earlier stages take the leftover iterations.
    function automatic int unsigned first_iter(input int unsigned s, input int unsigned iterations,
                                               input int unsigned stages);
        int unsigned base;
        int unsigned rem;
        base = iterations / stages;
        rem  = iterations % stages;
        return s * base + ((s < rem) ? s : rem);
    endfunction

    // |f| scaled by 2^width, truncated; valid for exponents below 129 and width < 46.
    function automatic logic [63:0] unpack_mag(input logic [31:0] f, input int unsigned width);
        logic [63:0] m;
        int          rsh;
        m   = 64'({1'b1, f[22:0]}) << 24;
        rsh = 174 - int'(width) - int'(f[30:23]);
        if (f[30:23] == 8'd0 || rsh >= 64) return '0;
        if (rsh <= 0) return m;
        return m >> rsh;
    endfunction

    // Signed fixed point (width fraction bits) to float32, mantissa truncated.
    function automatic logic [31:0] pack_float(input logic [63:0] v, input int unsigned width);
        logic [63:0] mag;
        logic [31:0] f;
        int          p;
        mag = v[63] ? -v : v;
        f   = '0;
        p   = -1;
        for (int i = 0; i < 64; i++) begin
            if (mag[i]) p = i;
        end
        if (p >= 0) begin
            f[31]    = v[63];
            f[30:23] = 8'(p - int'(width) + 127);
            if (p >= 23) f[22:0] = 23'(mag >> (p - 23));
            else         f[22:0] = 23'(mag << (23 - p));
        end
        return f;
    endfunction

endpackage

// File: rtl/cordic_stage.sv
// One pipeline stage: unrolled CORDIC micro-rotations for iterations [LO, HI)
// followed by the stage register, which loads only when the pipeline advances.
module cordic_stage
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH = 22,
    parameter int unsigned LO    = 0,
    parameter int unsigned HI    = 1,
    parameter int unsigned TAG_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   advance,
    input  stage_ctrl_t            in_ctrl,
    input  logic signed [WIDTH+1:0] in_x,
    input  logic signed [WIDTH+1:0] in_y,
    input  logic signed [WIDTH+1:0] in_z,
    input  logic [TAG_W-1:0]       in_tag,
    output stage_ctrl_t            out_ctrl,
    output logic signed [WIDTH+1:0] out_x,
    output logic signed [WIDTH+1:0] out_y,
    output logic signed [WIDTH+1:0] out_z,
    output logic [TAG_W-1:0]       out_tag
);

    localparam int unsigned DW = WIDTH + 2;
    localparam int unsigned NI = HI - LO;

    typedef logic [NI-1:0][DW-1:0] atan_tab_t;

    function automatic atan_tab_t build_atan();
        atan_tab_t t;
        for (int i = 0; i < int'(NI); i++) t[i] = DW'(atan_q(LO + i, WIDTH));
        return t;
    endfunction

    localparam atan_tab_t ATAN_TAB = build_atan();

    logic signed [DW-1:0] x_c, y_c, z_c, xs, ys;

    always_comb begin
        x_c = in_x;
        y_c = in_y;
        z_c = in_z;
        xs  = '0;
        ys  = '0;
        for (int i = 0; i < int'(NI); i++) begin
            xs = x_c >>> (int'(LO) + i);
            ys = y_c >>> (int'(LO) + i);
            if (z_c[DW-1]) begin
                x_c = x_c + ys;
                y_c = y_c - xs;
                z_c = z_c + $signed(ATAN_TAB[i]);
            end else begin
                x_c = x_c - ys;
                y_c = y_c + xs;
                z_c = z_c - $signed(ATAN_TAB[i]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_ctrl <= '0;
            out_x    <= '0;
            out_y    <= '0;
            out_z    <= '0;
            out_tag  <= '0;
        end else if (advance) begin
            out_ctrl <= in_ctrl;
            out_x    <= x_c;
            out_y    <= y_c;
            out_z    <= z_c;
            out_tag  <= in_tag;
        end
    end

endmodule

// File: rtl/cordic_sincos_pipe.sv
// Pipelined CORDIC sin/cos of a float32 angle with valid/ready handshake, tag
// pass-through, quadrant folding over [-pi, pi] and an out-of-range flag.
module cordic_sincos_pipe
    import cordic_pkg::*;
#(
    parameter int unsigned WIDTH      = 22,
    parameter int unsigned ITERATIONS = 16,
    parameter int unsigned STAGES     = 4,
    parameter int unsigned TAG_W      = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clk_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      angle,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      sin_out,
    output logic [31:0]      cos_out,
    output logic             out_err,
    output logic [TAG_W-1:0] out_tag
);

    localparam int unsigned DW = WIDTH + 2;
    localparam int unsigned FW = WIDTH + 4;
    localparam logic [FW-1:0]        PI_F      = FW'(pi_q(WIDTH));
    localparam logic [FW-1:0]        HALF_PI_F = FW'(half_pi_q(WIDTH));
    localparam logic signed [DW-1:0] K_D       = DW'(k_q(WIDTH));

    logic advance;

    stage_ctrl_t          ctrl [STAGES+1];
    logic signed [DW-1:0] xs   [STAGES+1];
    logic signed [DW-1:0] ys   [STAGES+1];
    logic signed [DW-1:0] zs   [STAGES+1];
    logic [TAG_W-1:0]     tags [STAGES+1];

    assign advance  = clk_en & (~out_valid | out_ready);
    assign in_ready = advance & ~reset;

    // Front end: unpack, fold into [-pi/2, pi/2], flag |angle| > pi.
    logic [FW-1:0]        mag, fmag;
    logic                 big, fold, fsign;
    stage_ctrl_t          ctrl_fe;
    logic signed [DW-1:0] z_fe;

    always_comb begin
        mag           = FW'(unpack_mag(angle, WIDTH));
        big           = angle[30:23] >= 8'd129;
        fold          = mag > HALF_PI_F;
        fmag          = fold ? PI_F - mag : mag;
        fsign         = angle[31] ^ fold;
        ctrl_fe.valid = in_valid & in_ready;
        ctrl_fe.neg   = fold;
        ctrl_fe.err   = big | (mag > PI_F);
        z_fe          = fsign ? -$signed(DW'(fmag)) : $signed(DW'(fmag));
    end

    assign ctrl[0] = ctrl_fe;
    assign xs[0]   = K_D;
    assign ys[0]   = '0;
    assign zs[0]   = z_fe;
    assign tags[0] = in_tag;

    for (genvar s = 0; s < int'(STAGES); s++) begin : g_stage
        cordic_stage #(
            .WIDTH (WIDTH),
            .LO    (first_iter(s, ITERATIONS, STAGES)),
            .HI    (first_iter(s + 1, ITERATIONS, STAGES)),
            .TAG_W (TAG_W)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .advance  (advance),
            .in_ctrl  (ctrl[s]),
            .in_x     (xs[s]),
            .in_y     (ys[s]),
            .in_z     (zs[s]),
            .in_tag   (tags[s]),
            .out_ctrl (ctrl[s+1]),
            .out_x    (xs[s+1]),
            .out_y    (ys[s+1]),
            .out_z    (zs[s+1]),
            .out_tag  (tags[s+1])
        );
    end

    // Back end: undo the fold, pack, force zero on out-of-range.
    logic signed [DW-1:0] cos_fx, sin_fx;

    always_comb begin
        cos_fx  = ctrl[STAGES].neg ? -xs[STAGES] : xs[STAGES];
        sin_fx  = ctrl[STAGES].neg ? -ys[STAGES] : ys[STAGES];
        cos_out = ctrl[STAGES].err ? '0 : pack_float(64'(cos_fx), WIDTH);
        sin_out = ctrl[STAGES].err ? '0 : pack_float(64'(sin_fx), WIDTH);
    end

    assign out_valid = ctrl[STAGES].valid;
    assign out_err   = ctrl[STAGES].err;
    assign out_tag   = tags[STAGES];

endmodule

// File: tb/tb_cordic_sincos_pipe.sv
// Randomised bench for cordic_sincos_pipe against a real-arithmetic sin/cos
// model carried through a latency-accurate slot array.
module tb_cordic_sincos_pipe;

    localparam int unsigned WIDTH      = 22;
    localparam int unsigned ITERATIONS = 16;
    localparam int unsigned STAGES     = 4;
    localparam int unsigned TAG_W      = 4;
    localparam real         PI         = 3.14159265358979323846;
    localparam real         TOL        = 1.0 / 16384.0;

    logic             clk = 1'b0;
    logic             reset, clk_en, in_valid, in_ready, out_valid, out_ready, out_err;
    logic [31:0]      angle, sin_out, cos_out;
    logic [TAG_W-1:0] in_tag, out_tag;

    int n_tests = 0;
    int n_fail  = 0;
    int stall_left  = 0;
    int freeze_left = 0;
    bit rand_ready  = 0;

    // Expected-result slots, index STAGES-1 is the output.
    bit               sv [STAGES];
    real              ss [STAGES];
    real              sc [STAGES];
    bit               se [STAGES];
    logic [TAG_W-1:0] st [STAGES];

    logic [31:0]      prev_sin, prev_cos;
    logic             prev_err, prev_val;
    logic [TAG_W-1:0] prev_tag;
    bit               prev_hold = 0;

    cordic_sincos_pipe #(
        .WIDTH      (WIDTH),
        .ITERATIONS (ITERATIONS),
        .STAGES     (STAGES),
        .TAG_W      (TAG_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .clk_en    (clk_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle     (angle),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sin_out   (sin_out),
        .cos_out   (cos_out),
        .out_err   (out_err),
        .out_tag   (out_tag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input real got, input real exp, input real tol);
        n_tests++;
        if (got > exp + tol || got < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %g expected %g (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    task automatic ref_model(input logic [31:0] a, output real s, output real c, output bit e);
        real v;
        v = f2r(a);
        e = (v > PI) || (v < -PI);
        s = e ? 0.0 : $sin(v);
        c = e ? 0.0 : $cos(v);
    endtask

    function automatic logic [31:0] rand_angle();
        logic [31:0] a;
        real         v;
        do begin
            a = {1'($urandom_range(1)), 8'($urandom_range(129, 90)), 23'($urandom)};
            v = f2r(a);
            if (v < 0.0) v = -v;
        end while (v > PI - 1.0e-4 && v < PI + 1.0e-4);
        return a;
    endfunction

    // One clock: check outputs against the model, then advance the model.
    task automatic cycle(output bit acc);
        bit mv, adv;
        if (stall_left > 0) begin
            out_ready = 1'b0;
            stall_left--;
        end else begin
            out_ready = rand_ready ? ($urandom_range(3) != 0) : 1'b1;
        end
        if (freeze_left > 0) begin
            clk_en = 1'b0;
            freeze_left--;
        end else begin
            clk_en = 1'b1;
        end
        #1;
        mv  = sv[STAGES-1];
        adv = clk_en && (!mv || out_ready);
        check("in_ready", real'(in_ready), real'(adv && !reset), 0.0);
        check("out_valid", real'(out_valid), real'(mv), 0.0);
        if (mv) begin
            check("sin", f2r(sin_out), ss[STAGES-1], TOL);
            check("cos", f2r(cos_out), sc[STAGES-1], TOL);
            check("out_err", real'(out_err), real'(se[STAGES-1]), 0.0);
            check("out_tag", real'(out_tag), real'(st[STAGES-1]), 0.0);
            if (se[STAGES-1]) begin
                check("err_sin_bits", real'(sin_out), 0.0, 0.0);
                check("err_cos_bits", real'(cos_out), 0.0, 0.0);
            end
        end
        if (prev_hold) begin
            check("hold_valid", real'(out_valid), real'(prev_val), 0.0);
            check("hold_sin", real'(sin_out), real'(prev_sin), 0.0);
            check("hold_cos", real'(cos_out), real'(prev_cos), 0.0);
            check("hold_err", real'(out_err), real'(prev_err), 0.0);
            check("hold_tag", real'(out_tag), real'(prev_tag), 0.0);
        end
        prev_val  = out_valid;
        prev_sin  = sin_out;
        prev_cos  = cos_out;
        prev_err  = out_err;
        prev_tag  = out_tag;
        prev_hold = !reset && !adv;
        acc = !reset && adv && in_valid;
        if (reset) begin
            for (int i = 0; i < int'(STAGES); i++) sv[i] = 1'b0;
        end else if (adv) begin
            for (int i = int'(STAGES) - 1; i > 0; i--) begin
                sv[i] = sv[i-1];
                ss[i] = ss[i-1];
                sc[i] = sc[i-1];
                se[i] = se[i-1];
                st[i] = st[i-1];
            end
            sv[0] = acc;
            ref_model(angle, ss[0], sc[0], se[0]);
            st[0] = in_tag;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] a, input logic [TAG_W-1:0] t);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        angle    = a;
        in_tag   = t;
        for (int k = 0; k < 100 && !acc; k++) cycle(acc);
        if (!acc) check("accept_timeout", 0.0, 1.0, 0.0);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int k = 0; k < n; k++) cycle(acc);
    endtask

    task automatic do_reset();
        bit acc;
        reset    = 1'b1;
        in_valid = 1'b1;
        angle    = rand_angle();
        in_tag   = '1;
        cycle(acc);
        reset    = 1'b0;
        in_valid = 1'b0;
        check("rst_valid", real'(out_valid), 0.0, 0.0);
        check("rst_sin", real'(sin_out), 0.0, 0.0);
        check("rst_cos", real'(cos_out), 0.0, 0.0);
        check("rst_err", real'(out_err), 0.0, 0.0);
        check("rst_tag", real'(out_tag), 0.0, 0.0);
    endtask

    initial begin
        reset     = 1'b1;
        clk_en    = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        angle     = '0;
        in_tag    = '0;
        for (int i = 0; i < int'(STAGES); i++) sv[i] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        do_reset();

        // Directed angles: 0, pi/6, +-3.0 (folded), 4.0 (out of range).
        send(32'h0000_0000, 4'd1);
        send(32'h3F06_0A92, 4'd2);
        send(32'h4040_0000, 4'd3);
        send(32'hC040_0000, 4'd4);
        send(32'h4080_0000, 4'd5);
        idle(STAGES + 2);

        // Backpressure: 8 back-to-back samples, out_ready low 5 cycles mid-stream.
        for (int i = 0; i < 8; i++) begin
            if (i == 5) stall_left = 5;
            send(rand_angle(), 4'(i));
        end
        idle(STAGES + 8);

        // Freeze mid-stream, then reset with samples in flight.
        for (int i = 0; i < 6; i++) begin
            if (i == 3) freeze_left = 3;
            send(rand_angle(), 4'(8 + i));
        end
        do_reset();
        idle(STAGES + 3);

        // Random stream with random gaps and random backpressure.
        rand_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            idle(int'($urandom_range(2)));
            send(rand_angle(), 4'($urandom));
        end
        rand_ready = 1'b0;
        idle(STAGES + 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
